keyspace_walker: RTL
====================

# keyspace_walker

Parametrised guess-index generator for the cracking pipeline: walks an arbitrary contiguous slice of the keyspace, one candidate per handshake. Lengths run from a minimum to a maximum, and the slice is set by a start vector and a count, so work can be partitioned across nodes. Outputs per-position charset indices plus the active length. Downstream charset ROMs turn the indices into ASCII, and the indices then feed the hash cores.

## Interface
- MAX_LEN, 16, maximum guess length in positions
- IDX_W, 8, width of one position index (charset up to 2^IDX_W symbols)
- LEN_W, $clog2(MAX_LEN+1), width of length fields
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  latch cfg_* and begin a run (sampled in IDLE/DONE only)
- abort  in  1  stop current run, return to IDLE
- cfg_charset_max  in  IDX_W  highest valid index (charset size − 1)
- cfg_min_len  in  LEN_W  first guess length
- cfg_max_len  in  LEN_W  last guess length
- cfg_start_idx  in  MAX_LEN*IDX_W  first guess; position 0 = least significant = bits [IDX_W-1:0]
- cfg_count  in  32  guesses to emit; 0 = run until keyspace exhausted
- out_valid  out  1  out_idx/out_len hold a guess
- out_ready  in  1  consumer accepts guess
- out_idx  out  MAX_LEN*IDX_W  per-position indices; positions ≥ out_len are 0
- out_len  out  LEN_W  active length of current guess
- busy  out  1  state == RUN
- done  out  1  run completed normally (level)
- cfg_err  out  1  one-cycle pulse: start rejected
- guesses_emitted  out  32  handshakes since last accepted start, wraps modulo 2^32

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; out_valid, busy, done and cfg_err = 0; out_idx, out_len and guesses_emitted = 0.
- **IDLE/DONE + start:** validate the config. Reject if any of these hold:
  - cfg_min_len == 0
  - cfg_min_len > cfg_max_len
  - cfg_max_len > MAX_LEN
  - any start position < cfg_min_len exceeds cfg_charset_max
- **On reject:** pulse cfg_err, state unchanged, done unchanged.
- **On accept:**
  - Latch the config.
  - Digits = cfg_start_idx, with positions ≥ cfg_min_len forced to 0.
  - len = cfg_min_len, remaining = cfg_count.
  - guesses_emitted = 0, done = 0.
  - Go to RUN.
- **RUN:** out_valid = 1. Advance only on out_valid && out_ready:
  - guesses_emitted += 1.
  - If cfg_count ≠ 0 and remaining == 1 → DONE.
  - Else if every position < len equals cfg_charset_max (wrap-around):
    - If len == cfg_max_len → DONE (keyspace exhausted).
    - Else len += 1 and all positions = 0.
  - Else add 1 at position 0 with ripple carry. A position equal to cfg_charset_max resets to 0 and carries. Carry never reaches positions ≥ len.
  - remaining decrements when cfg_count ≠ 0.
- Carry logic uses per-position "equals max" flags and prefix-AND lookahead. Each position is IDX_W bits compared against cfg_charset_max. Increments never exceed cfg_charset_max, so no IDX_W overflow is possible.
- **abort in RUN:** go to IDLE, out_valid = 0, done = 0. Ignored in other states.
- **start in RUN:** ignored. A simultaneous abort+start in RUN resolves to abort.
- Priority: reset > abort > handshake.
- cfg_* are don't-care outside the start cycle.

## Timing
- start accepted at cycle N → busy and out_valid high at N+1 presenting the first guess.
- cfg_err is high at N+1 on reject.
- Throughput: one guess per cycle with out_ready held high. Length rollover costs no bubble.
- Handshake at cycle M → next guess registered at M+1.
- Final handshake at M → out_valid = 0, busy = 0, done = 1 at M+1.
- out_idx/out_len are registered outputs, stable while out_valid && !out_ready.
- out_valid never drops without a handshake, except on abort or reset.
- reset asserted at any cycle → all outputs at reset values the following cycle.

## Test plan
- **Full keyspace:** charset_max=2, min=max=2, count=0, start=0, ready=1.
  - Expect 9 guesses (d1,d0): 00,01,02,10,11,12,20,21,22.
  - Expect done at cycle after 9th and guesses_emitted=9.
- **Length rollover:** charset_max=1, min=1, max=3.
  - Expect 14 guesses: len 1 ×2, len 2 ×4, len 3 ×8.
  - Each new length starts all-zero; no idle cycle between lengths.
- **Partition:** charset_max=25, min=max=4, start (d3..d0)=0,0,0,25, count=3.
  - Expect 0,0,0,25 → 0,0,1,0 → 0,0,1,1, then done.
- **Backpressure:** scenario 1 with out_ready randomly toggled.
  - Identical sequence; outputs stable while stalled.
  - One increment per handshake; done only after the 9th handshake.
- **Config errors:** min_len=0; then max_len=MAX_LEN+1; then start d0=3 with charset_max=2.
  - Expect a one-cycle cfg_err each time; out_valid stays 0, busy stays 0.
- **Reset/abort mid-run:** abort after 5 handshakes → IDLE, done=0, out_valid=0, guesses_emitted=5.
  - reset mid-run → all outputs zero the next cycle.
  - A new start then resumes normally from the new config.

Source files
------------

// File: rtl/keyspace_walker.sv
// Guess-index generator: walks a contiguous keyspace slice from min to max length,
// presenting one candidate (per-position charset indices plus length) per handshake.
module keyspace_walker #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [IDX_W-1:0]         cfg_charset_max,
    input  logic [LEN_W-1:0]         cfg_min_len,
    input  logic [LEN_W-1:0]         cfg_max_len,
    input  logic [MAX_LEN*IDX_W-1:0] cfg_start_idx,
    input  logic [31:0]              cfg_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAX_LEN*IDX_W-1:0] out_idx,
    output logic [LEN_W-1:0]         out_len,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [31:0]              guesses_emitted
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_next;
    logic [IDX_W-1:0]           cs_max;
    logic [LEN_W-1:0]           max_len;
    logic                       count_limited;
    logic [31:0]                remaining;
    logic [MAX_LEN*IDX_W-1:0]   digits;
    logic [LEN_W-1:0]           len;

    logic                       cfg_ok, accept, reject, handshake, finish, all_max;
    logic [MAX_LEN-1:0]         active, at_max;
    logic [MAX_LEN*IDX_W-1:0]   start_masked, digits_inc;

    // Config validation; positions at or above the first length are forced to zero.
    always_comb begin
        cfg_ok       = (cfg_min_len != '0) && (cfg_min_len <= cfg_max_len) &&
                       (cfg_max_len <= LEN_W'(MAX_LEN));
        start_masked = '0;
        for (int p = 0; p < MAX_LEN; p++) begin
            if (LEN_W'(p) < cfg_min_len) begin
                start_masked[p*IDX_W +: IDX_W] = cfg_start_idx[p*IDX_W +: IDX_W];
                if (cfg_start_idx[p*IDX_W +: IDX_W] > cfg_charset_max)
                    cfg_ok = 1'b0;
            end
        end
    end

    // Lookahead increment: a position bumps when every lower active position is at max.
    always_comb begin
        logic carry;
        carry      = 1'b1;
        active     = '0;
        at_max     = '0;
        digits_inc = digits;
        for (int p = 0; p < MAX_LEN; p++) begin
            active[p] = LEN_W'(p) < len;
            at_max[p] = digits[p*IDX_W +: IDX_W] == cs_max;
            if (active[p] && carry)
                digits_inc[p*IDX_W +: IDX_W] = at_max[p] ? '0
                                             : digits[p*IDX_W +: IDX_W] + IDX_W'(1);
            carry = carry & at_max[p];
        end
        all_max = &(at_max | ~active);
    end

    assign accept    = start && (state != RUN) && cfg_ok;
    assign reject    = start && (state != RUN) && !cfg_ok;
    assign handshake = (state == RUN) && out_ready && !abort;
    assign finish    = handshake && ((count_limited && remaining == 32'd1) ||
                                     (all_max && len == max_len));

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (accept) state_next = RUN;
            RUN: begin
                if (abort)       state_next = IDLE;
                else if (finish) state_next = DONE;
            end
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_max          <= '0;
            max_len         <= '0;
            count_limited   <= 1'b0;
            remaining       <= '0;
            digits          <= '0;
            len             <= '0;
            guesses_emitted <= '0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                cs_max          <= cfg_charset_max;
                max_len         <= cfg_max_len;
                count_limited   <= cfg_count != 32'd0;
                remaining       <= cfg_count;
                digits          <= start_masked;
                len             <= cfg_min_len;
                guesses_emitted <= '0;
                done            <= 1'b0;
            end else if (state == RUN && abort) begin
                done <= 1'b0;
            end else if (handshake) begin
                guesses_emitted <= guesses_emitted + 32'd1;
                if (count_limited) remaining <= remaining - 32'd1;
                if (finish) begin
                    done <= 1'b1;
                end else if (all_max) begin
                    len    <= len + LEN_W'(1);
                    digits <= '0;
                end else begin
                    digits <= digits_inc;
                end
            end
        end
    end

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_idx   = digits;
    assign out_len   = len;

endmodule
